data_bus_ram: RTL and testbench
===============================

Name: data_bus_ram

Overview:
- Responder for the rv32 core's data memory bus: services the core's read/write requests from an internal byte-maskable word RAM.
- Drives read value, ready and fault back to the core, with a configurable number of wait states.
- Sits opposite the core's data_* ports in simulation benches, formal harnesses and small SoC tops.
- Out-of-range, misaligned or malformed requests get a fault response.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
- WAIT_STATES, 1: extra cycles between acceptance and response; range 0..15.
- TIMER_ADDR, 32'h0001_0000: base of the 2-word timer window; optional feature only.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- address_in  input  32  byte address from the core.
- read_in  input  1  read request.
- write_in  input  1  write request.
- write_mask_in  input  4  byte-lane enables; bit i covers bits [8i+7:8i].
- write_value_in  input  32  write data.
- read_value_out  output  32  read data; valid only while ready_out=1 and fault_out=0.
- ready_out  output  1  one-cycle response strobe.
- fault_out  output  1  response is an error; only ever asserted together with ready_out.
- cycle_in  input  64  free-running cycle count; present only with DATA_BUS_RAM_TIMER_EN.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state IDLE; ready_out=0, fault_out=0, read_value_out=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If read_in|write_in: accept the request. Latch address, op, mask and data; decode for fault.
  - Next state is WAIT with counter=WAIT_STATES-1, or ACK if WAIT_STATES=0.
  - Otherwise stay in IDLE.
- WAIT: count down. At counter=0, go to ACK. Bus inputs are ignored while in WAIT.
- ACK:
  - ready_out=1 for exactly one cycle, then return to IDLE.
  - A new request may be accepted in the cycle after ACK.
  - For accept in cycle N, ready_out is high in cycle N+1+WAIT_STATES.
- Fault conditions, any of:
  - address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS);
  - address[1:0]!=0;
  - read_in and write_in both set.
- On a fault, the ACK cycle has fault_out=1 and read_value_out=0, and no RAM write occurs.
- Reads:
  - RAM word index = (address-BASE_ADDR)>>2, using log2(DEPTH_WORDS) bits.
  - The RAM is read synchronously on the accept edge; read_value_out is registered and presented in ACK.
  - read_value_out=0 in every non-ACK cycle.
- Writes:
  - Write into the RAM on the edge that leaves ACK, lanes per the latched mask.
  - Mask 4'b0000 is a legal no-op that still receives a normal ack.
  - A read issued in the cycle after a write's ACK returns the new data.
- Reset mid-operation:
  - Reset in any state returns to IDLE with outputs zeroed.
  - A pending write, including one in its ACK cycle, is dropped.
- Inputs held high during ACK are not re-accepted; acceptance occurs only in IDLE.

Optional Feature:
- Macro: DATA_BUS_RAM_TIMER_EN.
- When defined:
  - cycle_in port exists.
  - Aligned reads at TIMER_ADDR return cycle_in[31:0]; at TIMER_ADDR+4 they return cycle_in[63:32]. The value is sampled on the accept edge.
  - Writes to either timer word fault.
  - The timer window takes precedence over the RAM range.
- When undefined:
  - No cycle_in port.
  - Timer addresses decode as ordinary addresses: RAM if in range, otherwise fault.

Decomposition:
- Package data_bus_ram_pkg holds:
  - state enum (IDLE, WAIT, ACK);
  - TIMER_LO_OFFSET=0 and TIMER_HI_OFFSET=4;
  - decode result enum (DEC_RAM, DEC_TIMER, DEC_FAULT).
- Sub-module data_bus_ram_array: single-port synchronous RAM with 4 byte-write enables, parameterised by depth, with no reset. The top holds the FSM, decode and output registers.

Test Plan:
- Write 32'hDEADBEEF, mask 4'hF, to BASE+0x10, then read BASE+0x10 with WAIT_STATES=1 -> each ack arrives 2 cycles after accept; read returns 32'hDEADBEEF with fault_out=0.
- Write 32'h00AA0000, mask 4'b0100, over stored 32'h11223344, then read back -> returns 32'h11AA3344.
- Read BASE+4*DEPTH_WORDS; read BASE+2; assert read_in and write_in together -> each gets ready_out=1, fault_out=1, read_value_out=0, and RAM is unchanged.
- Back-to-back reads with WAIT_STATES=0 -> ready_out pulses every 2nd cycle, with one IDLE gap between acks.
- Write accepted, reset asserted during ACK, then read the same address -> old value returned; outputs are 0 in the cycle after reset.
- With DATA_BUS_RAM_TIMER_EN and cycle_in=64'h0000_0001_0000_0005 at accept -> TIMER_ADDR returns 32'h5, TIMER_ADDR+4 returns 32'h1, and a write to TIMER_ADDR faults.

Source files
------------

// File: rtl/data_bus_ram_pkg.sv
// Shared types and constants for the data_bus_ram responder.
// Holds the FSM state enum, the decode result enum, the latched request
// payload struct and the timer window word offsets.
package data_bus_ram_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MASK_W  = 4;
    localparam int unsigned COUNT_W = 4;

    localparam logic [31:0] TIMER_LO_OFFSET = 32'h0000_0000;
    localparam logic [31:0] TIMER_HI_OFFSET = 32'h0000_0004;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DEC_RAM   = 2'd0,
        DEC_TIMER = 2'd1,
        DEC_FAULT = 2'd2
    } decode_e;

    // Request fields held from acceptance until the ACK cycle
    typedef struct packed {
        logic              write;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } req_t;

endpackage

// File: rtl/data_bus_ram_array.sv
// Single-port synchronous word RAM with per-byte write enables, no reset.
// Ports:
//   clk      clock
//   addr     word index
//   rd_en    capture mem[addr] into rd_data on this edge
//   wr_en    write enabled lanes of wr_data into mem[addr] on this edge
//   wr_mask  byte-lane enables, bit i covers bits [8i+7:8i]
//   wr_data  write data
//   rd_data  registered read data (holds until the next rd_en)
module data_bus_ram_array
    import data_bus_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane write and registered read share the single address port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(MASK_W); i++) begin
                if (wr_mask[i]) begin
                    mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/data_bus_ram.sv
// Data memory bus responder for the rv32 core: services read/write requests
// from an internal byte-maskable word RAM with WAIT_STATES cycles of latency.
// Optional feature macro: DATA_BUS_RAM_TIMER_EN adds cycle_in and a 2-word
// read-only timer window at TIMER_ADDR.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   address_in       byte address
//   read_in/write_in request strobes (both set is a fault)
//   write_mask_in    byte-lane enables
//   write_value_in   write data
//   read_value_out   read data, nonzero only in a non-fault ACK cycle
//   ready_out        one-cycle response strobe
//   fault_out        error response, only with ready_out
//   cycle_in         free-running cycle count (timer build only)
module data_bus_ram
    import data_bus_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] TIMER_ADDR  = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address_in,
    input  logic              read_in,
    input  logic              write_in,
    input  logic [MASK_W-1:0] write_mask_in,
    input  logic [DATA_W-1:0] write_value_in,
    output logic [DATA_W-1:0] read_value_out,
    output logic              ready_out,
    output logic              fault_out
`ifdef DATA_BUS_RAM_TIMER_EN
    ,
    input  logic [63:0]       cycle_in
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [63:0] RAM_BYTES = 64'(DEPTH_WORDS) << 2;
    localparam logic [COUNT_W-1:0] WAIT_INIT =
        (WAIT_STATES == 0) ? COUNT_W'(0) : COUNT_W'(WAIT_STATES - 1);

    state_e            state;
    decode_e           dec_c;
    decode_e           dec_q;
    req_t              req_q;
    logic [AW-1:0]     idx_q;
    logic [COUNT_W-1:0] count_q;
    logic [31:0]       offset_c;
    logic [AW-1:0]     ram_addr_c;
    logic              accept_c;
    logic              ram_wr_c;
    logic [DATA_W-1:0] ram_rd;

    assign accept_c = (state == IDLE) && (read_in || write_in);
    assign offset_c = address_in - BASE_ADDR;

    // Request decode; the timer window (when built) overrides the RAM range
    always_comb begin
        dec_c = DEC_FAULT;
        if (read_in && write_in) begin
            dec_c = DEC_FAULT;
        end else if (address_in[1:0] != 2'b00) begin
            dec_c = DEC_FAULT;
`ifdef DATA_BUS_RAM_TIMER_EN
        end else if ((address_in == TIMER_ADDR + TIMER_LO_OFFSET) ||
                     (address_in == TIMER_ADDR + TIMER_HI_OFFSET)) begin
            dec_c = write_in ? DEC_FAULT : DEC_TIMER;
`endif
        end else if (64'(offset_c) < RAM_BYTES) begin
            dec_c = DEC_RAM;
        end
    end

    // Port address: incoming index while idle (read), latched index in ACK (write)
    assign ram_addr_c = (state == IDLE) ? AW'(offset_c >> 2) : idx_q;
    // Commit on the edge leaving ACK; a reset on that edge drops the write
    assign ram_wr_c = (state == ACK) && req_q.write && (dec_q == DEC_RAM) && !reset;

    data_bus_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .addr    (ram_addr_c),
        .rd_en   (accept_c),
        .wr_en   (ram_wr_c),
        .wr_mask (req_q.mask),
        .wr_data (req_q.data),
        .rd_data (ram_rd)
    );

`ifdef DATA_BUS_RAM_TIMER_EN
    logic [31:0] timer_q;

    // Timer word sampled on the accept edge
    always_ff @(posedge clk) begin
        if (accept_c) begin
            timer_q <= (address_in == TIMER_ADDR + TIMER_HI_OFFSET) ?
                       cycle_in[63:32] : cycle_in[31:0];
        end
    end

    // Registered read data, exposed only in a successful ACK cycle
    assign read_value_out = (ready_out && !fault_out) ?
                            ((dec_q == DEC_TIMER) ? timer_q : ram_rd) : '0;
`else
    logic unused_timer;
    assign unused_timer = ^{TIMER_ADDR, TIMER_LO_OFFSET, TIMER_HI_OFFSET};

    assign read_value_out = (ready_out && !fault_out) ? ram_rd : '0;
`endif

    // Response FSM with registered ready/fault
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ready_out <= 1'b0;
            fault_out <= 1'b0;
            count_q   <= '0;
            dec_q     <= DEC_FAULT;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        req_q.write <= write_in;
                        req_q.mask  <= write_mask_in;
                        req_q.data  <= write_value_in;
                        idx_q       <= AW'(offset_c >> 2);
                        dec_q       <= dec_c;
                        if (WAIT_STATES == 0) begin
                            state     <= ACK;
                            ready_out <= 1'b1;
                            fault_out <= (dec_c == DEC_FAULT);
                        end else begin
                            state   <= WAIT;
                            count_q <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (count_q == '0) begin
                        state     <= ACK;
                        ready_out <= 1'b1;
                        fault_out <= (dec_q == DEC_FAULT);
                    end else begin
                        count_q <= count_q - COUNT_W'(1);
                    end
                end
                ACK: begin
                    state     <= IDLE;
                    ready_out <= 1'b0;
                    fault_out <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    ready_out <= 1'b0;
                    fault_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_ram.sv
// Directed bench for data_bus_ram: instance a (WAIT_STATES=1) is the main
// checker, instance b (WAIT_STATES=0) shares the same inputs for the
// back-to-back timing scenario.
module tb_data_bus_ram;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] TADDR = 32'h0001_0000;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rv_a, rv_b;
    logic        ready_a, ready_b, fault_a, fault_b;
`ifdef DATA_BUS_RAM_TIMER_EN
    logic [63:0] cycle;
`endif

    int errors = 0;
    int checks = 0;

    int          got_lat;
    logic [31:0] got_rv;
    logic        got_flt;

    data_bus_ram #(
        .DEPTH_WORDS (16), .BASE_ADDR (BASE), .WAIT_STATES (1), .TIMER_ADDR (TADDR)
    ) dut_a (
        .clk (clk), .reset (reset), .address_in (address), .read_in (read),
        .write_in (write), .write_mask_in (mask), .write_value_in (wdata),
        .read_value_out (rv_a), .ready_out (ready_a), .fault_out (fault_a)
`ifdef DATA_BUS_RAM_TIMER_EN
        , .cycle_in (cycle)
`endif
    );

    data_bus_ram #(
        .DEPTH_WORDS (16), .BASE_ADDR (BASE), .WAIT_STATES (0), .TIMER_ADDR (TADDR)
    ) dut_b (
        .clk (clk), .reset (reset), .address_in (address), .read_in (read),
        .write_in (write), .write_mask_in (mask), .write_value_in (wdata),
        .read_value_out (rv_b), .ready_out (ready_b), .fault_out (fault_b)
`ifdef DATA_BUS_RAM_TIMER_EN
        , .cycle_in (cycle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request; records latency (cycles from accept cycle) and a's response
    task automatic bus_req(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [3:0] m, input logic [31:0] d);
        @(posedge clk); #1;
        address = addr; read = rd; write = wr; mask = m; wdata = d;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        got_lat = 1;
        while (!ready_a && got_lat < 10) begin
            @(posedge clk); #1;
            got_lat++;
        end
        got_rv  = rv_a;
        got_flt = fault_a;
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; mask = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready_a got %b exp 0", ready_a); end
        checks++; if (fault_a !== 1'b0) begin errors++; $display("FAIL reset_fault_a got %b exp 0", fault_a); end
        checks++; if (rv_a !== 32'h0) begin errors++; $display("FAIL reset_rv_a got %h exp 0", rv_a); end
        checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL reset_ready_b got %b exp 0", ready_b); end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        bus_req(BASE + 32'h10, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF);
        checks++; if (got_lat !== 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", got_lat); end
        checks++; if (got_flt !== 1'b0) begin errors++; $display("FAIL wr_fault got %b exp 0", got_flt); end
        bus_req(BASE + 32'h10, 1'b1, 1'b0, 4'h0, 32'h0);
        checks++; if (got_lat !== 2) begin errors++; $display("FAIL rd_latency got %0d exp 2", got_lat); end
        checks++; if (got_rv !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", got_rv); end
        checks++; if (got_flt !== 1'b0) begin errors++; $display("FAIL rd_fault got %b exp 0", got_flt); end
        @(posedge clk); #1;
        checks++; if (rv_a !== 32'h0) begin errors++; $display("FAIL rv_after_ack got %h exp 0", rv_a); end
    endtask

    task automatic test_mask();
        bus_req(BASE + 32'h14, 1'b0, 1'b1, 4'hF, 32'h1122_3344);
        bus_req(BASE + 32'h14, 1'b0, 1'b1, 4'b0100, 32'h00AA_0000);
        bus_req(BASE + 32'h14, 1'b1, 1'b0, 4'h0, 32'h0);
        checks++; if (got_rv !== 32'h11AA_3344) begin errors++; $display("FAIL mask_lane2 got %h exp 11aa3344", got_rv); end
        bus_req(BASE + 32'h14, 1'b0, 1'b1, 4'h0, 32'hFFFF_FFFF);
        checks++; if (got_lat !== 2 || got_flt !== 1'b0) begin errors++; $display("FAIL mask0_ack lat %0d flt %b exp 2/0", got_lat, got_flt); end
        bus_req(BASE + 32'h14, 1'b1, 1'b0, 4'h0, 32'h0);
        checks++; if (got_rv !== 32'h11AA_3344) begin errors++; $display("FAIL mask0_noop got %h exp 11aa3344", got_rv); end
    endtask

    task automatic test_faults();
        logic [31:0] f_addr [5];
        logic        f_rd   [5];
        logic        f_wr   [5];
        f_addr[0] = BASE + 32'h40;   f_rd[0] = 1'b1; f_wr[0] = 1'b0;
        f_addr[1] = BASE + 32'h2;    f_rd[1] = 1'b1; f_wr[1] = 1'b0;
        f_addr[2] = BASE - 32'h4;    f_rd[2] = 1'b1; f_wr[2] = 1'b0;
        f_addr[3] = BASE + 32'h12;   f_rd[3] = 1'b0; f_wr[3] = 1'b1;
        f_addr[4] = BASE + 32'h10;   f_rd[4] = 1'b1; f_wr[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_req(f_addr[i], f_rd[i], f_wr[i], 4'hF, 32'h0000_0000);
            checks++;
            if (got_lat !== 2 || got_flt !== 1'b1 || got_rv !== 32'h0) begin
                errors++;
                $display("FAIL fault_%0d lat %0d flt %b rv %h exp 2/1/0", i, got_lat, got_flt, got_rv);
            end
        end
        bus_req(BASE + 32'h10, 1'b1, 1'b0, 4'h0, 32'h0);
        checks++; if (got_rv !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fault_ram_intact got %h exp deadbeef", got_rv); end
    endtask

    task automatic test_back_to_back();
        logic exp_b [6];
        logic exp_a [6];
        exp_b[0] = 1; exp_b[1] = 0; exp_b[2] = 1; exp_b[3] = 0; exp_b[4] = 1; exp_b[5] = 0;
        exp_a[0] = 0; exp_a[1] = 1; exp_a[2] = 0; exp_a[3] = 0; exp_a[4] = 1; exp_a[5] = 0;
        @(posedge clk); #1;
        address = BASE + 32'h10; read = 1'b1; write = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ready_b !== exp_b[k] || rv_b !== (exp_b[k] ? 32'hDEAD_BEEF : 32'h0)) begin
                errors++;
                $display("FAIL b2b_b_%0d ready %b rv %h exp %b", k, ready_b, rv_b, exp_b[k]);
            end
            checks++;
            if (ready_a !== exp_a[k]) begin
                errors++;
                $display("FAIL b2b_a_%0d ready %b exp %b", k, ready_a, exp_a[k]);
            end
        end
        read = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        bus_req(BASE + 32'h18, 1'b0, 1'b1, 4'hF, 32'h0000_0055);
        @(posedge clk); #1;
        address = BASE + 32'h18; read = 1'b0; write = 1'b1; mask = 4'hF; wdata = 32'h0000_0099;
        @(posedge clk); #1;
        write = 1'b0;
        lat = 1;
        while (!ready_a && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (ready_a !== 1'b1 || lat !== 2) begin errors++; $display("FAIL rstmid_ack ready %b lat %0d exp 1/2", ready_a, lat); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready_a !== 1'b0 || fault_a !== 1'b0 || rv_a !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs ready %b fault %b rv %h exp 0", ready_a, fault_a, rv_a);
        end
        reset = 1'b0;
        bus_req(BASE + 32'h18, 1'b1, 1'b0, 4'h0, 32'h0);
        checks++; if (got_rv !== 32'h0000_0055) begin errors++; $display("FAIL rstmid_dropped got %h exp 00000055", got_rv); end
    endtask

`ifdef DATA_BUS_RAM_TIMER_EN
    task automatic test_timer();
        cycle = 64'h0000_0001_0000_0005;
        bus_req(TADDR, 1'b1, 1'b0, 4'h0, 32'h0);
        checks++; if (got_rv !== 32'h5 || got_flt !== 1'b0) begin errors++; $display("FAIL timer_lo got %h flt %b exp 5/0", got_rv, got_flt); end
        bus_req(TADDR + 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
        checks++; if (got_rv !== 32'h1 || got_flt !== 1'b0) begin errors++; $display("FAIL timer_hi got %h flt %b exp 1/0", got_rv, got_flt); end
        bus_req(TADDR, 1'b0, 1'b1, 4'hF, 32'h1234_5678);
        checks++; if (got_flt !== 1'b1) begin errors++; $display("FAIL timer_write got flt %b exp 1", got_flt); end
    endtask
`endif

    initial begin
`ifdef DATA_BUS_RAM_TIMER_EN
        cycle = '0;
`endif
        test_reset();
        test_write_read();
        test_mask();
        test_faults();
        test_back_to_back();
        test_reset_mid();
`ifdef DATA_BUS_RAM_TIMER_EN
        test_timer();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
